// File: rtl/dmem_pkg.sv
// +-----------------------------------------------------------------+
// | dmem_pkg : shared types and helpers for the dmem responder      |
// | Revision : 1.0                                                  |
// +-----------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

  localparam int LINE_W   = 256;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Line index of a byte address, wrapped modulo 2**idx_w.
  function automatic logic [ADDR_W-1:0] line_idx(input logic [ADDR_W-1:0] addr,
                                                 input int idx_w);
    logic [ADDR_W-1:0] mask;
    mask = (ADDR_W'(1) << idx_w) - ADDR_W'(1);
    return (addr >> OFFSET_W) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_line_array.sv
// +-----------------------------------------------------------------+
// | dmem_line_array : single-port line store with registered read   |
// | Revision        : 1.0                                           |
// +-----------------------------------------------------------------+
`default_nettype none

module dmem_line_array #(
  parameter int LINE_W    = dmem_pkg::LINE_W,
  parameter int MEM_LINES = 512,
  parameter int IDX_W     = $clog2(MEM_LINES)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] o_rdata
);

  // Storage is deliberately left out of reset so it can be preloaded.
  logic [LINE_W-1:0] r_mem [MEM_LINES];
  logic [LINE_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +-----------------------------------------------------------------+
// | dmem_responder : fixed-latency line memory behind a cache port  |
// | Revision       : 1.0                                            |
// +-----------------------------------------------------------------+
`default_nettype none

module dmem_responder #(
  parameter int LINE_W    = dmem_pkg::LINE_W,
  parameter int MEM_LINES = 512,
  parameter int LATENCY   = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        mem_enable_i,
  input  logic                        mem_write_i,
  input  logic [dmem_pkg::ADDR_W-1:0] mem_addr_i,
  input  logic [LINE_W-1:0]           mem_data_i,
  output logic [LINE_W-1:0]           mem_data_o,
  output logic                        mem_ack_o,
  output logic                        busy_o
);

  import dmem_pkg::*;

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(LATENCY - 1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_write;
  logic [LINE_W-1:0] r_wdata;
  logic              w_accept, w_finish, w_we, w_re;
  logic [ADDR_W-1:0] w_idx_full;

  assign w_idx_full = line_idx(mem_addr_i, IDX_W);
  wire w_unused_idx = &{1'b0, w_idx_full[ADDR_W-1:IDX_W]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_enable_i) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == c_cnt_last) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        // The edge closing the ack cycle already samples the next request,
        // giving a single-cycle gap between ack and re-accept.
        if (mem_enable_i) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx   <= w_idx_full[IDX_W-1:0];
        r_write <= mem_write_i;
        r_wdata <= mem_data_i;
      end
    end
  end

  // Reset on the completing edge must not let a write commit.
  assign w_we = w_finish &  r_write & ~rst_i;
  assign w_re = w_finish & ~r_write & ~rst_i;

  dmem_line_array #(
    .LINE_W    (LINE_W),
    .MEM_LINES (MEM_LINES),
    .IDX_W     (IDX_W)
  ) u_array (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (mem_data_o)
  );

  assign mem_ack_o = (r_state == S_DONE);
  assign busy_o    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +-----------------------------------------------------------------+
// | tb_dmem_responder : directed scoreboard bench for dmem_responder|
// | Revision          : 1.0                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_dmem_responder;

  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, wr, ack, busy;
  logic [31:0]   addr;
  logic [LW-1:0] wdata, rdata;
  logic          en1, wr1, ack1, busy1;
  logic [31:0]   addr1;
  logic [LW-1:0] wdata1, rdata1;

  int checks   = 0;
  int failures = 0;

  logic [LW-1:0] sb[$];
  logic [LW-1:0] sb1[$];

  always #5 clk = ~clk;

  dmem_responder #(.LINE_W(LW), .MEM_LINES(512), .LATENCY(10)) dut (
    .clk_i(clk), .rst_i(rst), .mem_enable_i(en), .mem_write_i(wr),
    .mem_addr_i(addr), .mem_data_i(wdata), .mem_data_o(rdata),
    .mem_ack_o(ack), .busy_o(busy)
  );

  dmem_responder #(.LINE_W(LW), .MEM_LINES(512), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .mem_enable_i(en1), .mem_write_i(wr1),
    .mem_addr_i(addr1), .mem_data_i(wdata1), .mem_data_o(rdata1),
    .mem_ack_o(ack1), .busy_o(busy1)
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle or in its ack cycle; returns at
  // the negedge of the ack cycle. prev is the read data held before ack.
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [LW-1:0] d, input logic [LW-1:0] exp_rd,
                     input logic [LW-1:0] prev);
    en = 1'b1; wr = w; addr = a; wdata = d;
    if (!w) sb.push_back(exp_rd);
    @(posedge clk);
    #1;
    en = 1'b0; wr = 1'b0; addr = 32'hFFFF_FFE0; wdata = '1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      chk_bit($sformatf("%s_ack_c%0d", tag, c), ack, (c == 10));
      if (c == 9) begin
        chk({tag, "_hold"}, rdata, prev);
        chk_bit({tag, "_busy"}, busy, 1'b1);
      end
      if (c == 10) begin
        if (w) chk({tag, "_wr_keep"}, rdata, prev);
        else if (sb.size() > 0) chk({tag, "_data"}, rdata, sb.pop_front());
      end
    end
  endtask

  initial begin
    int acks;
    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    en1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    dut.u_array.r_mem[3]  = {32{8'hA5}};
    dut.u_array.r_mem[1]  = 256'h11;
    dut.u_array.r_mem[2]  = 256'h22;
    dut1.u_array.r_mem[4] = 256'h44;
    dut1.u_array.r_mem[5] = 256'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_bit("rst_ack", ack, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk("rst_data", rdata, '0);
    chk_bit("rst_ack1", ack1, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 1: preloaded read
    txn("t1", 1'b0, 32'h60, '0, {32{8'hA5}}, '0);

    // 2: write, read back, low address bits ignored
    txn("t2w", 1'b1, 32'h80, 256'h1234, '0, {32{8'hA5}});
    txn("t2r", 1'b0, 32'h80, '0, 256'h1234, {32{8'hA5}});
    txn("t2lo", 1'b0, 32'h9F, '0, 256'h1234, 256'h1234);

    // 3: enable held high; request changes during BUSY are ignored
    en = 1'b1; wr = 1'b0; addr = 32'h20;
    sb.push_back(256'h11);
    sb.push_back(256'h22);
    sb.push_back(256'h22);
    @(posedge clk);
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      if (c == 3) begin addr = 32'h40; wdata = 256'hBAD; end
      if (c == 4) wr = 1'b1;
      if (c == 6) wr = 1'b0;
      if (c == 29) en = 1'b0;
      chk_bit($sformatf("t3_ack_c%0d", c), ack, (c == 10 || c == 21 || c == 32));
      if (ack && sb.size() > 0) chk($sformatf("t3_data_c%0d", c), rdata, sb.pop_front());
    end

    // 4: index wraps modulo MEM_LINES
    txn("t4w", 1'b1, 32'h4000, 256'hDEAD, '0, 256'h22);
    txn("t4r", 1'b0, 32'h0, '0, 256'hDEAD, 256'h22);

    // 5: reset during a write aborts it
    txn("t5w0", 1'b1, 32'h100, 256'hBEEF, '0, 256'hDEAD);
    txn("t5r0", 1'b0, 32'h100, '0, 256'hBEEF, 256'hDEAD);
    en = 1'b1; wr = 1'b1; addr = 32'h100; wdata = 256'hF00D;
    @(posedge clk);
    #1;
    en = 1'b0; wr = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_bit("t5_rst_ack", ack, 1'b0);
    chk_bit("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_data", rdata, '0);
    rst = 1'b0;
    acks = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("t5_no_ack", LW'(acks), '0);
    txn("t5r1", 1'b0, 32'h100, '0, 256'hBEEF, '0);

    // 6: LATENCY=1 instance, back-to-back reads
    en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h80;
    sb1.push_back(256'h44);
    sb1.push_back(256'h55);
    @(posedge clk);
    #1;
    addr1 = 32'hA0;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 2) en1 = 1'b0;
      if (c == 0) chk_bit("t6_busy", busy1, 1'b1);
      chk_bit($sformatf("t6_ack_c%0d", c), ack1, (c == 1 || c == 3));
      if (ack1 && sb1.size() > 0) chk($sformatf("t6_data_c%0d", c), rdata1, sb1.pop_front());
    end
    chk("t6_sb_drained", LW'(sb1.size() + sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
